// File: rtl/seg_scan_pkg.sv
// Shared types, glyph constants and helpers for the 7-segment scan-bus receiver.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned BCD_W      = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hA;
    localparam logic [BCD_W-1:0] BCD_BAD   = 4'hE;

    // One sample of the scan bus.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] sel;
        logic [SEG_W-1:0]      seg;
    } scan_smp_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational 7-segment glyph to BCD decode; unknown patterns give BCD_BAD and a flag.
module seg_glyph_decoder
    import seg_scan_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [BCD_W-1:0] bcd_c_o,
    output logic             bad_c_o
);

    always_comb begin
        bcd_c_o = BCD_BAD;
        bad_c_o = 1'b0;
        case (seg_i)
            SEG_0:     bcd_c_o = 4'h0;
            SEG_1:     bcd_c_o = 4'h1;
            SEG_2:     bcd_c_o = 4'h2;
            SEG_3:     bcd_c_o = 4'h3;
            SEG_4:     bcd_c_o = 4'h4;
            SEG_5:     bcd_c_o = 4'h5;
            SEG_6:     bcd_c_o = 4'h6;
            SEG_7:     bcd_c_o = 4'h7;
            SEG_8:     bcd_c_o = 4'h8;
            SEG_9:     bcd_c_o = 4'h9;
            SEG_BLANK: bcd_c_o = BCD_BLANK;
            default:   bad_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_receiver.sv
// Rebuilds 8 BCD digits from a multiplexed 7-segment scan bus and flags protocol faults.
// Define FRAME_LATCH_EN to publish digits/digit_valid only on whole-frame completion.
module seg_scan_receiver
    import seg_scan_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 2,
    parameter int unsigned TIMEOUT_W  = 12
)
(
    input  logic                        CLK,
    input  logic                        CLR,
    input  logic                        CE,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [NUM_DIGITS-1:0]       sel_in,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic                        frame_done,
    output logic                        sel_err,
    output logic                        glyph_err,
    output logic                        order_err,
    output logic                        link_lost
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DIG_W = BCD_W * NUM_DIGITS;

    scan_smp_t             smp_new, smp_q, cap_smp_q, cap_smp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic                  cap_q, cap_d;

    logic [DIG_W-1:0]      digits_q, digits_d;
    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d, seen_nxt;
    logic [IDX_W-1:0]      prev_q, prev_d;
    logic                  has_prev_q, has_prev_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic                  link_q, link_d;
    logic                  frame_q, frame_d;
    logic                  sel_err_q, sel_err_d;
    logic                  glyph_q, glyph_d;
    logic                  order_q, order_d;
    logic                  valid_cap;
`ifdef FRAME_LATCH_EN
    logic [DIG_W-1:0]      shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] shadow_valid_q, shadow_valid_d;
`endif

    logic [IDX_W-1:0]      cap_idx;
    logic [BCD_W-1:0]      cap_bcd;
    logic                  cap_bad;

    assign smp_new = '{sel: sel_in, seg: seg_in};
    assign cap_idx = onehot_to_idx(cap_smp_q.sel);

    seg_glyph_decoder u_dec (
        .seg_i   (cap_smp_q.seg),
        .bcd_c_o (cap_bcd),
        .bad_c_o (cap_bad)
    );

    // Glitch filter: capture once on the STABLE_CNT-th identical sample of a stable period.
    always_comb begin
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        cap_d     = cap_q;
        cap_smp_d = cap_smp_q;
        if (CE) begin
            cap_d = 1'b0;
            if (smp_new == smp_q) begin
                if (cnt_q != CNT_W'(STABLE_CNT)) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d   = '0;
                armed_d = 1'b1;
            end
            if (armed_d && cnt_d == CNT_W'(STABLE_CNT - 1)) begin
                cap_d     = 1'b1;
                armed_d   = 1'b0;
                cap_smp_d = smp_new;
            end
        end
    end

    // Capture processing, frame tracking and watchdog; a capture beats a coincident expiry.
    always_comb begin
        digits_d   = digits_q;
        valid_d    = valid_q;
        seen_d     = seen_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;
        wd_d       = wd_q;
        link_d     = link_q;
        frame_d    = 1'b0;
        sel_err_d  = 1'b0;
        glyph_d    = 1'b0;
        order_d    = 1'b0;
        valid_cap  = 1'b0;
        seen_nxt   = seen_q;
`ifdef FRAME_LATCH_EN
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
`endif
        if (CE) begin
            if (cap_q && cap_smp_q.sel != '0) begin
                if (is_onehot(cap_smp_q.sel)) valid_cap = 1'b1;
                else                          sel_err_d = 1'b1;
            end
            if (valid_cap) begin
                glyph_d  = cap_bad;
                seen_nxt = seen_q | (NUM_DIGITS'(1) << cap_idx);
                if (has_prev_q && cap_idx != prev_q + IDX_W'(1)) begin
                    order_d  = 1'b1;
                    seen_nxt = NUM_DIGITS'(1) << cap_idx;
                end
                prev_d     = cap_idx;
                has_prev_d = 1'b1;
                wd_d       = '0;
                link_d     = 1'b0;
`ifdef FRAME_LATCH_EN
                shadow_d[{cap_idx, 2'b00} +: BCD_W] = cap_bcd;
                shadow_valid_d[cap_idx]             = 1'b1;
`else
                digits_d[{cap_idx, 2'b00} +: BCD_W] = cap_bcd;
                valid_d[cap_idx]                    = 1'b1;
`endif
                if (seen_nxt == '1) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
`ifdef FRAME_LATCH_EN
                    digits_d = shadow_d;
                    valid_d  = shadow_valid_d;
`endif
                end else begin
                    seen_d = seen_nxt;
                end
            end else if (wd_q != '1) begin
                wd_d = wd_q + TIMEOUT_W'(1);
                if (wd_d == '1) begin
                    link_d     = 1'b1;
                    valid_d    = '0;
                    seen_d     = '0;
                    has_prev_d = 1'b0;
`ifdef FRAME_LATCH_EN
                    shadow_valid_d = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            smp_q      <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            cap_q      <= 1'b0;
            cap_smp_q  <= '0;
            digits_q   <= '0;
            valid_q    <= '0;
            seen_q     <= '0;
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            wd_q       <= '0;
            link_q     <= 1'b0;
            frame_q    <= 1'b0;
            sel_err_q  <= 1'b0;
            glyph_q    <= 1'b0;
            order_q    <= 1'b0;
`ifdef FRAME_LATCH_EN
            shadow_q       <= '0;
            shadow_valid_q <= '0;
`endif
        end else begin
            if (CE) smp_q <= smp_new;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            cap_q      <= cap_d;
            cap_smp_q  <= cap_smp_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            seen_q     <= seen_d;
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
            wd_q       <= wd_d;
            link_q     <= link_d;
            frame_q    <= frame_d;
            sel_err_q  <= sel_err_d;
            glyph_q    <= glyph_d;
            order_q    <= order_d;
`ifdef FRAME_LATCH_EN
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign sel_err     = sel_err_q;
    assign glyph_err   = glyph_q;
    assign order_err   = order_q;
    assign link_lost   = link_q;

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Scoreboard bench for seg_scan_receiver: directed scans push expected output events,
// a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_seg_scan_receiver;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        CE;
    logic [6:0]  seg_in;
    logic [7:0]  sel_in;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done, sel_err, glyph_err, order_err, link_lost;

    seg_scan_receiver #(.STABLE_CNT(2), .TIMEOUT_W(12)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .CE          (CE),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .sel_err     (sel_err),
        .glyph_err   (glyph_err),
        .order_err   (order_err),
        .link_lost   (link_lost)
    );

    always #5 CLK = ~CLK;

    // pulse vector order: {frame_done, sel_err, glyph_err, order_err}
    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_FD   = 4'b1000;
    localparam logic [3:0] P_SE   = 4'b0100;
    localparam logic [3:0] P_GE   = 4'b0010;
    localparam logic [3:0] P_OE   = 4'b0001;

    typedef struct {
        logic [3:0]  p;
        logic [31:0] d;
        logic [7:0]  v;
        logic        l;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ce_cnt  = 0;
    int          start_ce = 0;
    int          t_fd = 0;
    logic [31:0] exp_dig;
    logic [7:0]  exp_val;
    logic [7:0]  sel_v;

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    always @(posedge CLK) if (CE) ce_cnt <= ce_cnt + 1;

    // Monitor: any pulse or change of a level output is one presented event.
    logic [31:0] prev_dig;
    logic [7:0]  prev_val;
    logic        prev_link;
    logic [3:0]  cur_p;
    exp_t        e;

    always @(negedge CLK) begin
        cur_p = {frame_done, sel_err, glyph_err, order_err};
        if (!CLR && (cur_p != 4'b0 || digits != prev_dig || digit_valid != prev_val || link_lost != prev_link)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got pulses=%b digits=%h valid=%h link=%b at ce=%0d, want no event",
                         cur_p, digits, digit_valid, link_lost, ce_cnt);
            end else begin
                e = exp_q.pop_front();
                chk("ev_pulses", 32'(cur_p), 32'(e.p));
                chk("ev_digits", digits, e.d);
                chk("ev_valid", 32'(digit_valid), 32'(e.v));
                chk("ev_link", 32'(link_lost), 32'(e.l));
                chk("ev_time", 32'(ce_cnt), 32'(e.at));
            end
        end
        prev_dig  = digits;
        prev_val  = digit_valid;
        prev_link = link_lost;
    end

    task automatic apply(input logic [7:0] s, input logic [6:0] g);
        sel_in   = s;
        seg_in   = g;
        start_ce = ce_cnt;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic [7:0] s, input logic [6:0] g, input int n);
        apply(s, g);
        cycles(n);
    endtask

    task automatic expect_ev(input logic [3:0] p, input logic [31:0] d, input logic [7:0] v,
                             input logic l, input int at);
        exp_t x;
        x.p = p; x.d = d; x.v = v; x.l = l; x.at = at;
        exp_q.push_back(x);
    endtask

    initial begin
        CE = 1'b1; CLR = 1'b1; sel_in = 8'h00; seg_in = 7'h00;
        cycles(3);
        chk("rst_digits", digits, 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_pulses", 32'({frame_done, sel_err, glyph_err, order_err}), 32'h0);
        chk("rst_link", 32'(link_lost), 32'h0);
        CLR = 1'b0;
        cycles(4);

        // Full in-order scan, digits 1..8.
        exp_dig = 32'h0;
        exp_val = 8'h0;
        for (int k = 0; k < 8; k++) begin
            sel_v = 8'(1 << k);
            apply(sel_v, glyph(k + 1));
            exp_dig[4*k +: 4] = 4'(k + 1);
            exp_val[k] = 1'b1;
            expect_ev((k == 7) ? P_FD : P_NONE, exp_dig, exp_val, 1'b0, start_ce + 3);
            cycles(16);
        end
        chk("scan_digits", digits, 32'h87654321);
        chk("scan_valid", 32'(digit_valid), 32'hFF);

        // Second frame with a one-sample glitch; only frame_done is visible.
        step(8'h01, glyph(1), 16);
        step(8'h04, 7'h7F, 1);
        for (int k = 1; k < 8; k++) begin
            sel_v = 8'(1 << k);
            apply(sel_v, glyph(k + 1));
            if (k == 7) expect_ev(P_FD, 32'h87654321, 8'hFF, 1'b0, start_ce + 3);
            cycles(16);
        end

        // Non-one-hot select.
        apply(8'h06, 7'h3F);
        expect_ev(P_SE, 32'h87654321, 8'hFF, 1'b0, start_ce + 3);
        cycles(16);

        // Unknown glyph on digit 3.
        step(8'h01, glyph(1), 16);
        step(8'h02, glyph(2), 16);
        step(8'h04, glyph(3), 16);
        apply(8'h08, 7'h01);
        expect_ev(P_GE, 32'h8765E321, 8'hFF, 1'b0, start_ce + 3);
        cycles(16);
        for (int k = 4; k < 8; k++) begin
            sel_v = 8'(1 << k);
            apply(sel_v, glyph(k + 1));
            if (k == 7) expect_ev(P_FD, 32'h8765E321, 8'hFF, 1'b0, start_ce + 3);
            cycles(16);
        end

        // Out-of-order: 01, 02, 08 restarts the frame at digit 3.
        step(8'h01, glyph(1), 16);
        step(8'h02, glyph(2), 16);
        apply(8'h08, glyph(4));
        expect_ev(P_OE, 32'h87654321, 8'hFF, 1'b0, start_ce + 3);
        cycles(16);
        step(8'h10, glyph(5), 16);
        step(8'h20, glyph(6), 16);
        step(8'h40, glyph(7), 16);
        step(8'h80, glyph(8), 16);
        step(8'h01, glyph(1), 16);
        step(8'h02, glyph(2), 16);
        apply(8'h04, glyph(3));
        expect_ev(P_FD, 32'h87654321, 8'hFF, 1'b0, start_ce + 3);
        t_fd = start_ce + 3;
        cycles(16);

        // CE low: bus garbage must be ignored.
        CE = 1'b0; sel_in = 8'h5A; seg_in = 7'h12;
        cycles(5);
        sel_in = 8'h04; seg_in = glyph(3); CE = 1'b1;

        // Watchdog expiry with a frozen bus.
        expect_ev(P_NONE, 32'h87654321, 8'h00, 1'b1, t_fd + 4095);
        cycles(4200);
        chk("wd_link", 32'(link_lost), 32'h1);
        chk("wd_valid", 32'(digit_valid), 32'h0);
        chk("wd_digits_hold", digits, 32'h87654321);

        // Resume: no order error after expiry, link recovers on first capture.
        apply(8'h08, glyph(4));
        expect_ev(P_NONE, 32'h87654321, 8'h08, 1'b0, start_ce + 3);
        cycles(16);
        apply(8'h10, glyph(5));
        expect_ev(P_NONE, 32'h87654321, 8'h18, 1'b0, start_ce + 3);
        cycles(16);

        // Asynchronous clear in the middle of a digit.
        apply(8'h20, glyph(6));
        cycles(1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        CLR = 1'b1;
        #1;
        chk("clr_digits", digits, 32'h0);
        chk("clr_valid", 32'(digit_valid), 32'h0);
        chk("clr_pulses", 32'({frame_done, sel_err, glyph_err, order_err}), 32'h0);
        chk("clr_link", 32'(link_lost), 32'h0);
        cycles(2);
        CLR = 1'b0;
        start_ce = ce_cnt;
        expect_ev(P_NONE, 32'h00600000, 8'h20, 1'b0, start_ce + 3);
        cycles(16);

        chk("final_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_receiver.md
Name: seg_scan_receiver

Overview:
- Receive end of the multiplexed 7-segment scan bus: samples the time-multiplexed segment pattern and one-hot digit select and rebuilds the 8 displayed digits as BCD nibbles.
- Used as a loop-back monitor in the chess-clock display path and by self-check benches. It also flags protocol faults: bad select, unknown glyph, out-of-order scan, and lost scan.

Parameters:
- STABLE_CNT, 2, consecutive identical CE samples of {sel_in, seg_in} required before a capture (glitch filter, range 1..15).
- TIMEOUT_W, 12, width of the no-capture watchdog; link_lost is set after 2^TIMEOUT_W-1 CE cycles without a capture.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  asynchronous reset, active-high.
- CE  in  1  sample enable; all state advances only when CE=1.
- seg_in  in  7  segment pattern, active-high, bit0=a … bit6=g.
- sel_in  in  8  digit select, one-hot; bit k = digit k+1.
- digits  out  32  digit k BCD code in bits [4k+3:4k].
- digit_valid  out  8  bit k set once digit k has been captured since reset/timeout.
- frame_done  out  1  one-CLK pulse when all 8 digits have been captured in the current frame.
- sel_err  out  1  one-CLK pulse on a stable, non-zero, non-one-hot select.
- glyph_err  out  1  one-CLK pulse on capture of an unknown pattern.
- order_err  out  1  one-CLK pulse when the captured index is not prev+1 mod 8.
- link_lost  out  1  level; watchdog expired.

Behaviour:
- Reset (CLR=1, asynchronous): all outputs 0, digits=32'h0, stability counter 0, armed=1, seen mask 0, no previous index, watchdog 0.
- Sampling: each CE edge registers {sel_in, seg_in} into smp. Stable counter:
  - increments (saturating at STABLE_CNT) when the new sample equals smp;
  - otherwise clears to 0 and sets armed=1.
- Capture event: fires on the CE edge where the counter reaches STABLE_CNT-1 with armed=1 (the STABLE_CNT-th identical sample). It then clears armed, so each stable period captures at most once.
- Outputs update on the CLK edge following the capture. Latency from first new sample to the digits update is STABLE_CNT+1 CE edges.
- sel==0 at capture: idle, no effect except watchdog.
- Non-one-hot non-zero select: pulse sel_err, no digit write.
- Glyph decode:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00 → 4'hA (blank).
  - Any other pattern → 4'hE and pulse glyph_err; the digit is still written.
- On a valid capture of index k:
  - write nibble k, set digit_valid[k], set seen[k].
  - If a previous index exists and k != (prev+1)&7, pulse order_err and clear seen to only bit k.
  - prev←k.
- When seen becomes 8'hFF: pulse frame_done in that same output cycle; seen←0.
- Watchdog: counts CE cycles and is zeroed by any valid capture. On reaching all-ones:
  - set link_lost, clear digit_valid and seen, forget prev;
  - digits hold their last values.
  - link_lost clears on the next valid capture.
- Simultaneous events: sel_err, glyph_err and order_err are mutually exclusive per capture, except that glyph_err and order_err may pulse together. A watchdog expiry and a capture in the same cycle resolve as capture wins.
- CE=0: everything holds, pulses are 0.

Optional Feature:
- FRAME_LATCH_EN defined:
  - captured nibbles go to a shadow register;
  - digits loads the full shadow only on the frame_done cycle, so there is no tearing;
  - digit_valid updates the same way.
- Undefined: digits updates per capture as described above.

Decomposition:
- Shared package seg_scan_pkg:
  - segment glyph constants SEG_0..SEG_9, SEG_BLANK;
  - BCD_BLANK=4'hA, BCD_BAD=4'hE;
  - NUM_DIGITS=8;
  - a one-hot-to-index function.
- One natural sub-module, seg_glyph_decoder: combinational 7→4 decode with bad-glyph flag, reused by other display monitors.

Test Plan:
- Drive sel 01,02,…,80 with glyphs 1,2,3,4,5,6,7,8, each held 16 CE cycles → digits=32'h87654321, digit_valid=FF, one frame_done pulse after the 8th capture.
- Single-cycle glitch: sel=04, seg=7F for 1 CE cycle between stable digits, STABLE_CNT=2 → no capture, no error.
- Stable sel=8'h06 for 16 CE cycles → exactly one sel_err pulse, digits unchanged.
- Digit 3 with seg=7'h01 → nibble 3 = E, one glyph_err pulse.
- Scan 01,02 then 08 → order_err pulse, seen=08, no frame_done until 08..80,01..04 completes.
- Stop CE-driven changes for 4095 CE cycles (TIMEOUT_W=12) → link_lost=1, digit_valid=0. Resume a valid scan → link_lost=0 after the first capture. Assert CLR mid-scan → all outputs 0 immediately.
